// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register: captures the decoded control word and operands each cycle,
// with flush (wrong-path kill), freeze (hazard hold) and bubble masking of control bits.
module id_exe_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4,
    parameter int CMD_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              freeze,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [CMD_W-1:0]  id_exe_cmd,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_wb_en,
    input  logic              id_branch,
    input  logic              id_s,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_val_rn,
    input  logic [DATA_W-1:0] id_val_rm,
    input  logic              id_imm,
    input  logic [11:0]       id_shift_operand,
    input  logic [23:0]       id_signed_imm_24,
    input  logic [REG_AW-1:0] id_dest,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_c_in,
    output logic              exe_valid,
    output logic [CMD_W-1:0]  exe_exe_cmd,
    output logic              exe_mem_read,
    output logic              exe_mem_write,
    output logic              exe_wb_en,
    output logic              exe_branch,
    output logic              exe_s,
    output logic [DATA_W-1:0] exe_pc,
    output logic [DATA_W-1:0] exe_val_rn,
    output logic [DATA_W-1:0] exe_val_rm,
    output logic              exe_imm,
    output logic [11:0]       exe_shift_operand,
    output logic [23:0]       exe_signed_imm_24,
    output logic [REG_AW-1:0] exe_dest,
    output logic [REG_AW-1:0] exe_src1,
    output logic [REG_AW-1:0] exe_src2,
    output logic              exe_c_in
);

    localparam int CTRL_W = 1 + CMD_W + 5;
    localparam int DBUS_W = 3 * DATA_W + 1 + 12 + 24 + 3 * REG_AW + 1;

    logic [CTRL_W-1:0] ctrl_reg, ctrl_next;
    logic [DBUS_W-1:0] data_reg, data_next;
    logic [CTRL_W-1:0] id_ctrl;
    logic [DBUS_W-1:0] id_data;

    // A bubble carries no control: valid, command and strobes all collapse to zero.
    assign id_ctrl = id_valid ? {1'b1, id_exe_cmd, id_mem_read, id_mem_write,
                                 id_wb_en, id_branch, id_s}
                              : '0;

    assign id_data = {id_pc, id_val_rn, id_val_rm, id_imm, id_shift_operand,
                      id_signed_imm_24, id_dest, id_src1, id_src2, id_c_in};

    // Flush wins over freeze: a stalled instruction behind a taken branch is wrong-path.
    always_comb begin
        ctrl_next = ctrl_reg;
        data_next = data_reg;
        if (flush) begin
            ctrl_next = '0;
            data_next = '0;
        end else if (!freeze) begin
            ctrl_next = id_ctrl;
            data_next = id_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_reg <= '0;
            data_reg <= '0;
        end else begin
            ctrl_reg <= ctrl_next;
            data_reg <= data_next;
        end
    end

    assign {exe_valid, exe_exe_cmd, exe_mem_read, exe_mem_write,
            exe_wb_en, exe_branch, exe_s} = ctrl_reg;

    assign {exe_pc, exe_val_rn, exe_val_rm, exe_imm, exe_shift_operand,
            exe_signed_imm_24, exe_dest, exe_src1, exe_src2, exe_c_in} = data_reg;

endmodule

// File: tb/tb_id_exe_reg.sv
// Directed-vector bench for id_exe_reg: reset, load, freeze, flush-over-freeze,
// bubble masking and reset during a stall.
module tb_id_exe_reg;

    logic        clk;
    logic        rst_n;
    logic        freeze;
    logic        flush;
    logic        id_valid;
    logic [3:0]  id_exe_cmd;
    logic        id_mem_read, id_mem_write, id_wb_en, id_branch, id_s;
    logic [31:0] id_pc, id_val_rn, id_val_rm;
    logic        id_imm;
    logic [11:0] id_shift_operand;
    logic [23:0] id_signed_imm_24;
    logic [3:0]  id_dest, id_src1, id_src2;
    logic        id_c_in;

    logic        exe_valid;
    logic [3:0]  exe_exe_cmd;
    logic        exe_mem_read, exe_mem_write, exe_wb_en, exe_branch, exe_s;
    logic [31:0] exe_pc, exe_val_rn, exe_val_rm;
    logic        exe_imm;
    logic [11:0] exe_shift_operand;
    logic [23:0] exe_signed_imm_24;
    logic [3:0]  exe_dest, exe_src1, exe_src2;
    logic        exe_c_in;

    int num_vectors;
    int num_miscompares;

    id_exe_reg #(.DATA_W(32), .REG_AW(4), .CMD_W(4)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .freeze            (freeze),
        .flush             (flush),
        .id_valid          (id_valid),
        .id_exe_cmd        (id_exe_cmd),
        .id_mem_read       (id_mem_read),
        .id_mem_write      (id_mem_write),
        .id_wb_en          (id_wb_en),
        .id_branch         (id_branch),
        .id_s              (id_s),
        .id_pc             (id_pc),
        .id_val_rn         (id_val_rn),
        .id_val_rm         (id_val_rm),
        .id_imm            (id_imm),
        .id_shift_operand  (id_shift_operand),
        .id_signed_imm_24  (id_signed_imm_24),
        .id_dest           (id_dest),
        .id_src1           (id_src1),
        .id_src2           (id_src2),
        .id_c_in           (id_c_in),
        .exe_valid         (exe_valid),
        .exe_exe_cmd       (exe_exe_cmd),
        .exe_mem_read      (exe_mem_read),
        .exe_mem_write     (exe_mem_write),
        .exe_wb_en         (exe_wb_en),
        .exe_branch        (exe_branch),
        .exe_s             (exe_s),
        .exe_pc            (exe_pc),
        .exe_val_rn        (exe_val_rn),
        .exe_val_rm        (exe_val_rm),
        .exe_imm           (exe_imm),
        .exe_shift_operand (exe_shift_operand),
        .exe_signed_imm_24 (exe_signed_imm_24),
        .exe_dest          (exe_dest),
        .exe_src1          (exe_src1),
        .exe_src2          (exe_src2),
        .exe_c_in          (exe_c_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
        num_vectors++;
        if (observed !== expected) begin
            num_miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end else begin
            $display("vec %s ok: %0h", tag, observed);
        end
    endtask

    task automatic drive_word(input logic v, input logic [3:0] cmd, input logic mr,
                              input logic mw, input logic wb, input logic br,
                              input logic s, input logic [31:0] pc,
                              input logic [31:0] rn, input logic [31:0] rm,
                              input logic [3:0] dest);
        id_valid     = v;
        id_exe_cmd   = cmd;
        id_mem_read  = mr;
        id_mem_write = mw;
        id_wb_en     = wb;
        id_branch    = br;
        id_s         = s;
        id_pc        = pc;
        id_val_rn    = rn;
        id_val_rm    = rm;
        id_dest      = dest;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        num_vectors     = 0;
        num_miscompares = 0;
        rst_n  = 1'b0;
        freeze = 1'b0;
        flush  = 1'b0;
        id_imm           = 1'b1;
        id_shift_operand = 12'hA5C;
        id_signed_imm_24 = 24'h80_1234;
        id_src1          = 4'd9;
        id_src2          = 4'd11;
        id_c_in          = 1'b1;
        drive_word(1'b1, 4'b1001, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                   32'hDEAD_BEEF, 32'h1234_5678, 32'h8765_4321, 4'd15);
        #12;
        rst_n = 1'b1;

        // 1. Reset asserted between edges with a live valid word held in the register
        step();
        check_vec("preload_valid", 64'(exe_valid), 64'd1);
        check_vec("preload_pc", 64'(exe_pc), 64'hDEAD_BEEF);
        #2;
        rst_n = 1'b0;
        #1;
        check_vec("rst_valid", 64'(exe_valid), 64'd0);
        check_vec("rst_ctrl", 64'({exe_exe_cmd, exe_mem_read, exe_mem_write,
                                   exe_wb_en, exe_branch, exe_s}), 64'd0);
        check_vec("rst_pc", 64'(exe_pc), 64'd0);
        check_vec("rst_rn_rm", {exe_val_rn, exe_val_rm}, 64'd0);
        check_vec("rst_misc", 64'({exe_imm, exe_shift_operand, exe_signed_imm_24,
                                   exe_dest, exe_src1, exe_src2, exe_c_in}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 2. ADD-like word passes through bit-exact after one edge
        drive_word(1'b1, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                   32'h0000_0008, 32'h0000_0005, 32'h0000_0003, 4'd2);
        id_c_in = 1'b0;
        step();
        check_vec("add_valid", 64'(exe_valid), 64'd1);
        check_vec("add_cmd", 64'(exe_exe_cmd), 64'h2);
        check_vec("add_ctrl", 64'({exe_mem_read, exe_mem_write, exe_wb_en,
                                   exe_branch, exe_s}), 64'b00100);
        check_vec("add_rn_rm", {exe_val_rn, exe_val_rm}, 64'h0000_0005_0000_0003);
        check_vec("add_pc", 64'(exe_pc), 64'h8);
        check_vec("add_dest", 64'(exe_dest), 64'd2);
        check_vec("add_passthru", 64'({exe_imm, exe_shift_operand, exe_signed_imm_24,
                                       exe_src1, exe_src2, exe_c_in}),
                  64'({1'b1, 12'hA5C, 24'h80_1234, 4'd9, 4'd11, 1'b0}));

        // 3. LDR loaded, then held through 3 frozen edges while ID shows an STR
        @(negedge clk);
        drive_word(1'b1, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
                   32'h0000_0010, 32'h0000_0100, 32'h0000_0004, 4'd3);
        step();
        @(negedge clk);
        freeze = 1'b1;
        drive_word(1'b1, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                   32'h0000_0014, 32'h0000_0200, 32'h0000_0008, 4'd5);
        for (int i = 0; i < 3; i++) begin
            step();
            check_vec($sformatf("frz%0d_ctrl", i),
                      64'({exe_valid, exe_mem_read, exe_mem_write, exe_wb_en}),
                      64'b1101);
            check_vec($sformatf("frz%0d_rn_dest", i), 64'({exe_val_rn, exe_dest}),
                      64'({32'h0000_0100, 4'd3}));
        end
        @(negedge clk);
        freeze = 1'b0;
        step();
        check_vec("str_ctrl", 64'({exe_valid, exe_mem_read, exe_mem_write, exe_wb_en}),
                  64'b1010);
        check_vec("str_rn_dest", 64'({exe_val_rn, exe_dest}), 64'({32'h0000_0200, 4'd5}));

        // 4. Flush overrides freeze and clears data as well as control
        @(negedge clk);
        freeze = 1'b1;
        flush  = 1'b1;
        drive_word(1'b1, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
                   32'h0000_0040, 32'h0000_0777, 32'h0000_0888, 4'd14);
        step();
        check_vec("flush_ctrl", 64'({exe_valid, exe_branch, exe_wb_en, exe_exe_cmd}), 64'd0);
        check_vec("flush_data", 64'({exe_pc, exe_dest}), 64'd0);
        @(negedge clk);
        freeze = 1'b0;
        flush  = 1'b0;

        // 5. Bubble: control strobes masked despite being set on the inputs
        drive_word(1'b0, 4'b0100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
                   32'h0000_0050, 32'h0000_ABCD, 32'h0000_0001, 4'd6);
        step();
        check_vec("bubble_ctrl", 64'({exe_valid, exe_mem_write, exe_wb_en,
                                      exe_s, exe_exe_cmd}), 64'd0);

        // 6. CMP held by freeze, then reset mid-stall
        @(negedge clk);
        drive_word(1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                   32'h0000_0060, 32'h0000_0009, 32'h0000_0009, 4'd0);
        step();
        @(negedge clk);
        freeze = 1'b1;
        drive_word(1'b1, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                   32'h0000_0064, 32'h0000_0011, 32'h0000_0022, 4'd7);
        step();
        check_vec("cmp_held", 64'({exe_valid, exe_s, exe_exe_cmd}), 64'b1_1_0100);
        #2;
        rst_n = 1'b0;
        #1;
        check_vec("rst_frz_ctrl", 64'({exe_valid, exe_s, exe_exe_cmd}), 64'd0);
        check_vec("rst_frz_pc", 64'(exe_pc), 64'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        freeze = 1'b0;
        step();
        check_vec("post_rst_ctrl", 64'({exe_valid, exe_wb_en, exe_s, exe_exe_cmd}),
                  64'b1_1_0_0010);
        check_vec("post_rst_data", {exe_val_rn, exe_val_rm}, 64'h0000_0011_0000_0022);
        check_vec("post_rst_dest", 64'(exe_dest), 64'd7);

        $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_miscompares);
        $finish;
    end

endmodule
